// File: rtl/shadow_scoreboard.sv
// Shadow-memory checker beside the CPU memory interface: records completed data
// writes in a direct-mapped store and checks fetch/data read completions against it.
module shadow_scoreboard #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int INDEX_W      = 8,
    parameter int CNT_W        = 16,
    parameter bit SHARED_IMAGE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_a_i,
    input  logic [ADDR_W-1:0]     address_a_i,
    input  logic                  resp_a_i,
    input  logic [DATA_W-1:0]     rdata_a_i,
    input  logic                  read_b_i,
    input  logic                  write_b_i,
    input  logic [ADDR_W-1:0]     address_b_i,
    input  logic [DATA_W-1:0]     wdata_b_i,
    input  logic [DATA_W/8-1:0]   mbe_b_i,
    input  logic                  resp_b_i,
    input  logic [DATA_W-1:0]     rdata_b_i,
    input  logic                  clear_i,
    output logic                  init_done_o,
    output logic                  mismatch_a_o,
    output logic                  mismatch_b_o,
    output logic                  proto_err_o,
    output logic [CNT_W-1:0]      err_count_o,
    output logic [CNT_W-1:0]      untracked_count_o,
    output logic                  cap_valid_o,
    output logic                  cap_chan_o,
    output logic [ADDR_W-1:0]     cap_addr_o,
    output logic [DATA_W-1:0]     cap_expected_o,
    output logic [DATA_W-1:0]     cap_detected_o
);

    localparam int MBE_W = DATA_W / 8;
    localparam int OFF_W = $clog2(MBE_W);
    localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;
    localparam int DEPTH = 1 << INDEX_W;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e               state_q, state_d;
    logic [INDEX_W-1:0]   ptr_q, ptr_d;

    logic [DATA_W-1:0]    data_mem [DEPTH];
    logic [TAG_W-1:0]     tag_mem  [DEPTH];
    logic [MBE_W-1:0]     vld_mem  [DEPTH];

    logic                 mis_a_q, mis_a_d, mis_b_q, mis_b_d, proto_q, proto_d;
    logic [CNT_W-1:0]     err_q, err_d, untr_q, untr_d;
    logic                 cap_valid_q, cap_valid_d, cap_chan_q, cap_chan_d;
    logic [ADDR_W-1:0]    cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0]    cap_exp_q, cap_exp_d, cap_det_q, cap_det_d;

    function automatic logic [DATA_W-1:0] expand(input logic [MBE_W-1:0] m);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < MBE_W; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
        logic [CNT_W:0] s;
        s = {1'b0, c} + (CNT_W+1)'(n);
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    logic               run, a_fire, b_proto, b_wr, b_rd;
    logic [INDEX_W-1:0] idx_a, idx_b;
    logic [TAG_W-1:0]   tag_a, tag_b;
    logic               hit_a, hit_b, chk_a, chk_b, mis_a, mis_b, untr_a, untr_b;
    logic [DATA_W-1:0]  msk_a, msk_b, exp_a, exp_b, det_a, det_b;

    assign run     = (state_q == S_RUN);
    assign a_fire  = run && read_a_i && resp_a_i;
    assign b_proto = run && read_b_i && write_b_i && resp_b_i;
    assign b_wr    = run && write_b_i && !read_b_i && resp_b_i;
    assign b_rd    = run && read_b_i && !write_b_i && resp_b_i;

    assign idx_a = address_a_i[OFF_W +: INDEX_W];
    assign idx_b = address_b_i[OFF_W +: INDEX_W];
    assign tag_a = address_a_i[ADDR_W-1 -: TAG_W];
    assign tag_b = address_b_i[ADDR_W-1 -: TAG_W];

    // Lookups read the store as it stands before this edge's write (read-before-write).
    assign hit_a = (tag_mem[idx_a] == tag_a) && (|vld_mem[idx_a]);
    assign hit_b = (tag_mem[idx_b] == tag_b) && (|vld_mem[idx_b]);
    assign msk_a = expand(vld_mem[idx_a]);
    assign msk_b = expand(vld_mem[idx_b]);
    assign exp_a = data_mem[idx_a] & msk_a;
    assign exp_b = data_mem[idx_b] & msk_b;
    assign det_a = rdata_a_i & msk_a;
    assign det_b = rdata_b_i & msk_b;

    assign chk_a  = a_fire && SHARED_IMAGE && hit_a;
    assign chk_b  = b_rd && hit_b;
    assign mis_a  = chk_a && (exp_a != det_a);
    assign mis_b  = chk_b && (exp_b != det_b);
    assign untr_a = a_fire && !chk_a;
    assign untr_b = b_rd && !chk_b;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        mis_a_d     = mis_a;
        mis_b_d     = mis_b;
        proto_d     = proto_q | b_proto;
        err_d       = sat_add(err_q, {1'b0, mis_a} + {1'b0, mis_b});
        untr_d      = sat_add(untr_q, {1'b0, untr_a} + {1'b0, untr_b});
        cap_valid_d = cap_valid_q;
        cap_chan_d  = cap_chan_q;
        cap_addr_d  = cap_addr_q;
        cap_exp_d   = cap_exp_q;
        cap_det_d   = cap_det_q;

        if (state_q == S_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (&ptr_q) state_d = S_RUN;
        end

        if (clear_i) begin
            err_d       = '0;
            untr_d      = '0;
            cap_valid_d = 1'b0;
        end else if (!cap_valid_q && (mis_a || mis_b)) begin
            cap_valid_d = 1'b1;
            cap_chan_d  = !mis_a;
            cap_addr_d  = mis_a ? address_a_i : address_b_i;
            cap_exp_d   = mis_a ? exp_a : exp_b;
            cap_det_d   = mis_a ? det_a : det_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_INIT;
            ptr_q       <= '0;
            mis_a_q     <= 1'b0;
            mis_b_q     <= 1'b0;
            proto_q     <= 1'b0;
            err_q       <= '0;
            untr_q      <= '0;
            cap_valid_q <= 1'b0;
            cap_chan_q  <= 1'b0;
            cap_addr_q  <= '0;
            cap_exp_q   <= '0;
            cap_det_q   <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            mis_a_q     <= mis_a_d;
            mis_b_q     <= mis_b_d;
            proto_q     <= proto_d;
            err_q       <= err_d;
            untr_q      <= untr_d;
            cap_valid_q <= cap_valid_d;
            cap_chan_q  <= cap_chan_d;
            cap_addr_q  <= cap_addr_d;
            cap_exp_q   <= cap_exp_d;
            cap_det_q   <= cap_det_d;
        end
    end

    // The store has no reset; the INIT sweep invalidates every entry instead.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            vld_mem[ptr_q] <= '0;
        end else if (b_wr) begin
            tag_mem[idx_b] <= tag_b;
            vld_mem[idx_b] <= hit_b ? (vld_mem[idx_b] | mbe_b_i) : mbe_b_i;
            for (int i = 0; i < MBE_W; i++) begin
                if (mbe_b_i[i]) data_mem[idx_b][8*i +: 8] <= wdata_b_i[8*i +: 8];
            end
        end
    end

    assign init_done_o       = run;
    assign mismatch_a_o      = mis_a_q;
    assign mismatch_b_o      = mis_b_q;
    assign proto_err_o       = proto_q;
    assign err_count_o       = err_q;
    assign untracked_count_o = untr_q;
    assign cap_valid_o       = cap_valid_q;
    assign cap_chan_o        = cap_chan_q;
    assign cap_addr_o        = cap_addr_q;
    assign cap_expected_o    = cap_exp_q;
    assign cap_detected_o    = cap_det_q;

endmodule

// File: doc/shadow_scoreboard.md
# shadow_scoreboard

Synthesizable, parametrised shadow-memory checker that sits beside the CPU's memory interface: one read-only fetch channel (A) and one read/write data channel (B). It tracks completed data writes in a direct-mapped shadow store and checks every completed read against it. Mismatches are reported through registered pulses, saturating counters and a sticky first-error capture. The block supports FPGA and emulation runs where the behavioural checker cannot be used.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DATA_W`, 32: word width; multiple of 8; `MBE_W = DATA_W/8`.
- `INDEX_W`, 8: shadow store has 2^INDEX_W word entries.
- `CNT_W`, 16: width of the error and untracked counters.
- `SHARED_IMAGE`, 1: 1 means channel A is checked against the data shadow (self-modifying code is visible); 0 means channel A reads are never checked.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `read_a` in 1; `address_a` in ADDR_W; `resp_a` in 1; `rdata_a` in DATA_W: fetch channel.
- `read_b` in 1; `write_b` in 1; `address_b` in ADDR_W; `wdata_b` in DATA_W; `mbe_b` in MBE_W; `resp_b` in 1; `rdata_b` in DATA_W: data channel.
- `clear` in 1: synchronous clear of counters and capture.
- `init_done` out 1: initialisation sweep is complete.
- `mismatch_a`, `mismatch_b` out 1: one-cycle mismatch pulses.
- `proto_err` out 1: sticky flag, set when `read_b` and `write_b` are asserted together with `resp_b`.
- `err_count` out CNT_W; `untracked_count` out CNT_W.
- `cap_valid` out 1; `cap_chan` out 1 (0 = A, 1 = B); `cap_addr` out ADDR_W; `cap_expected` out DATA_W; `cap_detected` out DATA_W.

## Operation
- **Word alignment.** Word index is `address[$clog2(MBE_W) +: INDEX_W]`. Tag is the address bits above the index. Low byte-offset bits are ignored.
- **Shadow store contents.** Each entry holds a data word, a tag and a per-byte valid mask.
- **FSM states:**
  - INIT: `ptr` counts 0 .. 2^INDEX_W−1 and clears the valid masks, one entry per cycle. All channel events are ignored and not counted. Leaves to RUN after the last entry; `init_done` rises in the same cycle.
  - RUN: normal checking.
  - Reset from any state returns to INIT with `ptr` = 0.
- **Data write completion** (`write_b && resp_b`, `read_b` = 0):
  - Tag hit: merge the bytes enabled by `mbe_b` and set their valid bits.
  - Tag miss: replace the entry. The new tag is installed and the valid mask equals `mbe_b`.
- **Read completion** (`read_a && resp_a`, or `read_b && resp_b` with `write_b` = 0): look up the entry.
  - Tag miss, or no valid byte: the read is untracked. `untracked_count` increments by 1 (per channel event) and no check is made.
  - Otherwise only the valid bytes are compared. Any difference is a mismatch.
- **Channel A when `SHARED_IMAGE` = 0.** Completions count as untracked.
- **`proto_err` case.** The event is neither written nor checked; `proto_err` sets and stays set until reset.
- **Simultaneous A read and B write to the same word.** A is compared against the pre-write contents (read-before-write).
- **Error counting.** `err_count` increments by the number of mismatching channels that cycle (0, 1 or 2) and saturates at 2^CNT_W−1. `untracked_count` follows the same rule.
- **First-error capture.** On the first mismatch while `cap_valid` = 0, capture the channel, address, expected data (invalid bytes zeroed) and detected data (masked the same way). If both channels mismatch in the same cycle, channel A is captured. The capture is held until `clear`.
- **`clear`.** Zeroes both counters and `cap_valid`. It does not affect `proto_err` or the shadow contents. If `clear` and a mismatch occur in the same cycle, `clear` wins.

## Timing
- **Reset values.** Every output is 0; FSM is in INIT.
- **Initialisation.** INIT lasts exactly 2^INDEX_W cycles after `rst_n` deasserts.
- **Handshake.** Requests are held stable until and including the `resp` cycle. The block samples only on the `resp` cycle and never back-pressures.
- **Mismatch latency.** `mismatch_a` / `mismatch_b`, the counters and the capture update on the edge after the response edge (1-cycle latency). Pulses last exactly 1 cycle.
- **Write visibility.** A write completing at edge N is visible to a read completing at edge N+1.
- **Back-to-back traffic.** Completions on consecutive cycles are all processed with no bubbles.

## Test plan
- **Reset and INIT:** Release reset with INDEX_W=4 → `init_done` = 0 for 16 cycles, then 1. Reads issued during INIT do not change `untracked_count`.
- **Tracked read, match and mismatch:**
  - Write 0xDEADBEEF to 0x100 with mbe=4'hF, then read back 0xDEADBEEF → no pulse.
  - Read back 0xDEADBEEE instead → `mismatch_b` pulses for 1 cycle, `err_count`=1, capture = {B, 0x100, 0xDEADBEEF, 0xDEADBEEE}.
- **Partial writes:** Write 0x000000AA to 0x200 with mbe=4'b0001, then read 0x123456AA → match. Read 0x123456AB → mismatch; expected = 0x000000AA, detected = 0x000000AB.
- **Aliasing and untracked reads:**
  - Write to 0x100, then read 0x100 + 4·2^INDEX_W (tag miss) → `untracked_count`+1, no pulse.
  - A read of a never-written word also increments `untracked_count`.
- **Simultaneous events:** Same cycle: A reads 0x100 (returning the old value 0xDEADBEEF) while B writes 0x11111111 to 0x100 → no A mismatch. An A read on the next cycle expects 0x11111111.
- **Saturation, clear and protocol error:**
  - With CNT_W=2, 5 mismatches → `err_count`=3.
  - `clear` → 0, `cap_valid`=0.
  - `read_b`+`write_b`+`resp_b` together → `proto_err`=1, persists through `clear`, drops only on reset.
